// File: rtl/wimpfi_pkg.sv
// Shared WimpFi constants and the transmit-buffer read FSM state type.
package wimpfi_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [BYTE_W-1:0] SFD_BYTE      = 8'hD0;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    FETCH,
    WAIT_RD,
    SEND,
    DONE
  } txd_rd_state_t;

endpackage

// File: rtl/txd_read_fsm.sv
// Transmit frame buffer read side: streams preamble, SFD, then buffered bytes
// onto a valid/ready byte interface and pulses done_reading at the end.
module txd_read_fsm
  import wimpfi_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned PRE_BYTES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done_writing,
  input  logic [ADDR_W-1:0] byte_count,
  output logic              ren,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [BYTE_W-1:0] rdata,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done_reading
);

  localparam int unsigned PRE_W = $clog2(PRE_BYTES + 1);

  txd_rd_state_t     state, state_n;
  logic [ADDR_W-1:0] len, len_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [PRE_W-1:0]  pre_cnt, pre_cnt_n;
  logic [ADDR_W-1:0] r_addr_n;
  logic [BYTE_W-1:0] tx_data_n;
  logic              tx_valid_n;
  logic              xfer_c;

  assign xfer_c = tx_valid & tx_ready;

  // Next state and next values of every registered output.
  always_comb begin
    state_n    = state;
    len_n      = len;
    idx_n      = idx;
    pre_cnt_n  = pre_cnt;
    r_addr_n   = r_addr;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;

    unique case (state)
      IDLE: begin
        if (done_writing) begin
          len_n      = byte_count;
          idx_n      = '0;
          pre_cnt_n  = '0;
          tx_data_n  = PREAMBLE_BYTE;
          tx_valid_n = 1'b1;
          state_n    = PRE;
        end
      end
      PRE: begin
        if (xfer_c) begin
          pre_cnt_n = pre_cnt + PRE_W'(1);
          if (pre_cnt_n == PRE_W'(PRE_BYTES)) begin
            tx_data_n = SFD_BYTE;
            state_n   = SFD;
          end
        end
      end
      SFD: begin
        if (xfer_c) begin
          tx_valid_n = 1'b0;
          state_n    = (len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        state_n = WAIT_RD;
      end
      WAIT_RD: begin
        tx_data_n  = rdata;
        tx_valid_n = 1'b1;
        state_n    = SEND;
      end
      SEND: begin
        if (xfer_c) begin
          tx_valid_n = 1'b0;
          if (idx == len - ADDR_W'(1)) begin
            state_n = DONE;
          end else begin
            idx_n   = idx + ADDR_W'(1);
            state_n = FETCH;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Address is presented together with the single-cycle read strobe.
    if (state_n == FETCH) begin
      r_addr_n = idx_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      len          <= '0;
      idx          <= '0;
      pre_cnt      <= '0;
      ren          <= 1'b0;
      r_addr       <= '0;
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      busy         <= 1'b0;
      done_reading <= 1'b0;
    end else begin
      state        <= state_n;
      len          <= len_n;
      idx          <= idx_n;
      pre_cnt      <= pre_cnt_n;
      ren          <= (state_n == FETCH);
      r_addr       <= r_addr_n;
      tx_data      <= tx_data_n;
      tx_valid     <= tx_valid_n;
      busy         <= (state_n != IDLE);
      done_reading <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_txd_read_fsm.sv
// Directed bench for txd_read_fsm with a sync RAM model and a frame-level
// reference stream checked on every transfer, read and done pulse.
module tb_txd_read_fsm;
  import wimpfi_pkg::*;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned PRE_BYTES = 2;

  logic              clk;
  logic              reset;
  logic              done_writing;
  logic [ADDR_W-1:0] byte_count;
  logic              ren;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done_reading;

  txd_read_fsm #(.ADDR_W(ADDR_W), .PRE_BYTES(PRE_BYTES)) dut (
    .clk          (clk),
    .reset        (reset),
    .done_writing (done_writing),
    .byte_count   (byte_count),
    .ren          (ren),
    .r_addr       (r_addr),
    .rdata        (rdata),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .done_reading (done_reading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram [256];
  always @(posedge clk) if (ren) rdata <= ram[r_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each frame is PRE_BYTES preambles, the SFD, then ram[0..n-1].
  int         exp_len_q[$];
  logic [7:0] exp_byte_q[$];
  int         exp_addr_q[$];
  logic [7:0] obs_byte_q[$];
  int         obs_addr_q[$];
  int         done_cnt = 0, ren_cnt = 0, start_cnt = 0;
  logic       busy_prev = 0, done_prev = 0, stall_prev = 0;
  logic [7:0] stall_data = 0;
  int         mlen;

  always @(negedge clk) begin
    if (!reset) begin
      exp_len_q.delete();
      exp_byte_q.delete();
      exp_addr_q.delete();
      busy_prev  = 0;
      done_prev  = 0;
      stall_prev = 0;
    end else begin
      if (busy && !busy_prev) begin
        start_cnt++;
        if (exp_len_q.size() == 0) check("unexpected_start", 1, 0);
        else begin
          mlen = exp_len_q.pop_front();
          for (int i = 0; i < PRE_BYTES; i++) exp_byte_q.push_back(8'h55);
          exp_byte_q.push_back(8'hD0);
          for (int i = 0; i < mlen; i++) begin
            exp_byte_q.push_back(ram[i]);
            exp_addr_q.push_back(i);
          end
        end
        check("start_valid", tx_valid, 1);
        check("start_byte", tx_data, 8'h55);
      end
      if (done_prev) check("busy_after_done", busy, 0);
      if (stall_prev) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, stall_data);
      end
      if (tx_valid && tx_ready) begin
        obs_byte_q.push_back(tx_data);
        if (exp_byte_q.size() == 0) check("extra_byte", 1, 0);
        else check("stream_byte", tx_data, exp_byte_q.pop_front());
      end
      if (ren) begin
        ren_cnt++;
        obs_addr_q.push_back(int'(r_addr));
        if (exp_addr_q.size() == 0) check("extra_read", 1, 0);
        else check("read_addr", r_addr, exp_addr_q.pop_front());
      end
      if (done_reading) begin
        done_cnt++;
        check("done_stream_empty", exp_byte_q.size(), 0);
        check("done_reads_empty", exp_addr_q.size(), 0);
        check("busy_in_done", busy, 1);
      end
      busy_prev  = busy;
      done_prev  = done_reading;
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  logic [7:0] lit_q[$];
  int         lit_a[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int n);
    byte_count = ADDR_W'(n);
    exp_len_q.push_back(n);
    done_writing = 1'b1;
    tick();
    done_writing = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    for (int c = 0; c < budget && done_cnt < target; c++) tick();
    check(name, done_cnt, target);
  endtask

  task automatic wait_read(input int addr, input string name);
    bit hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (ren && r_addr == ADDR_W'(addr)) hit = 1;
    end
    check(name, hit, 1);
  endtask

  task automatic check_lits(input string name);
    check({name, "_nbytes"}, obs_byte_q.size(), lit_q.size());
    for (int i = 0; i < lit_q.size() && i < obs_byte_q.size(); i++)
      check({name, "_byte"}, obs_byte_q[i], lit_q[i]);
    check({name, "_nreads"}, obs_addr_q.size(), lit_a.size());
    for (int i = 0; i < lit_a.size() && i < obs_addr_q.size(); i++)
      check({name, "_addr"}, obs_addr_q[i], lit_a[i]);
  endtask

  task automatic clear_obs();
    obs_byte_q.delete();
    obs_addr_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int d0, r0, s0, errs, maxa;
  bit seen;

  initial begin
    reset = 1'b0; done_writing = 1'b0; byte_count = '0; tx_ready = 1'b1;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    repeat (10) tick();
    check("rst_ren", ren, 0);
    check("rst_r_addr", r_addr, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_reading, 0);
    reset = 1'b1;
    repeat (2) tick();

    // Basic frame
    ram[0] = 8'hA1; ram[1] = 8'hB2; ram[2] = 8'hC3;
    clear_obs(); d0 = done_cnt;
    start_frame(3);
    wait_done(d0 + 1, 100, "basic_done");
    repeat (3) tick();
    check("basic_busy_low", busy, 0);
    check("basic_one_done", done_cnt, d0 + 1);
    lit_q = '{8'h55, 8'h55, 8'hD0, 8'hA1, 8'hB2, 8'hC3};
    lit_a = '{0, 1, 2};
    check_lits("basic");

    // Backpressure on byte B2
    clear_obs(); d0 = done_cnt;
    start_frame(3);
    wait_read(1, "bp_read1");
    @(posedge clk); #1 tx_ready = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (tx_valid) seen = 1;
    end
    check("bp_valid_seen", seen, 1);
    r0 = ren_cnt;
    check("bp_data", tx_data, 8'hB2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_data", tx_data, 8'hB2);
      check("bp_valid", tx_valid, 1);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    check("bp_no_extra_ren", ren_cnt, r0);
    wait_done(d0 + 1, 100, "bp_done");
    repeat (3) tick();
    check_lits("bp");

    // Zero length
    clear_obs(); d0 = done_cnt; r0 = ren_cnt;
    start_frame(0);
    wait_done(d0 + 1, 100, "zero_done");
    repeat (3) tick();
    check("zero_no_ren", ren_cnt, r0);
    check("zero_one_done", done_cnt, d0 + 1);
    lit_q = '{8'h55, 8'h55, 8'hD0};
    lit_a = {};
    check_lits("zero");

    // Max length
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    clear_obs(); d0 = done_cnt; r0 = ren_cnt;
    start_frame(255);
    wait_done(d0 + 1, 3000, "max_done");
    repeat (3) tick();
    check("max_nbytes", obs_byte_q.size(), 258);
    errs = 0;
    for (int i = 0; i < 255 && i + 3 < obs_byte_q.size(); i++)
      if (obs_byte_q[i + 3] !== 8'(i)) errs++;
    check("max_data_errs", errs, 0);
    check("max_nreads", ren_cnt - r0, 255);
    maxa = 0;
    foreach (obs_addr_q[i]) if (obs_addr_q[i] > maxa) maxa = obs_addr_q[i];
    check("max_addr_ceiling", maxa, 8'hFE);
    if (obs_addr_q.size() > 0) check("max_last_addr", obs_addr_q[$], 8'hFE);

    // Reset mid-frame
    ram[0] = 8'hA1; ram[1] = 8'hB2; ram[2] = 8'hC3;
    clear_obs(); d0 = done_cnt;
    start_frame(3);
    wait_read(1, "rmid_read1");
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check("rmid_ren", ren, 0);
    check("rmid_r_addr", r_addr, 0);
    check("rmid_tx_data", tx_data, 0);
    check("rmid_tx_valid", tx_valid, 0);
    check("rmid_busy", busy, 0);
    check("rmid_done", done_reading, 0);
    tick(); tick();
    reset = 1'b1;
    repeat (5) tick();
    check("rmid_no_done", done_cnt, d0);
    clear_obs();
    start_frame(3);
    wait_done(d0 + 1, 100, "rmid_restart_done");
    repeat (3) tick();
    lit_q = '{8'h55, 8'h55, 8'hD0, 8'hA1, 8'hB2, 8'hC3};
    lit_a = '{0, 1, 2};
    check_lits("rmid_restart");

    // Start while busy, then a held request at frame end
    clear_obs(); d0 = done_cnt; s0 = start_cnt;
    start_frame(3);
    repeat (4) tick();
    done_writing = 1'b1; byte_count = 8'd7;
    repeat (2) tick();
    done_writing = 1'b0;
    tick();
    byte_count = 8'd2;
    exp_len_q.push_back(2);
    done_writing = 1'b1;
    wait_done(d0 + 1, 100, "sb_first_done");
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    check("sb_restart_seen", seen, 1);
    @(posedge clk); #1 done_writing = 1'b0;
    wait_done(d0 + 2, 100, "sb_second_done");
    repeat (10) tick();
    check("sb_total_done", done_cnt, d0 + 2);
    check("sb_starts", start_cnt - s0, 2);
    check("sb_idle", busy, 0);
    lit_q = '{8'h55, 8'h55, 8'hD0, 8'hA1, 8'hB2, 8'hC3, 8'h55, 8'h55, 8'hD0, 8'hA1, 8'hB2};
    lit_a = '{0, 1, 2, 0, 1};
    check_lits("sb");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
